// File: rtl/prime_sieve_ctrl.sv
// Sieve of Eratosthenes builder over 0..255 with a round-robin primality query port.
// Optional hit counter output prime_hits is enabled by defining PRIME_SIEVE_STATS_EN.
module prime_sieve_ctrl #(
    parameter int N_REQ = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [8*N_REQ-1:0]       req_num,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     rsp_valid,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic                     rsp_prime
`ifdef PRIME_SIEVE_STATS_EN
    ,
    output logic [15:0]              prime_hits
`endif
);

    localparam int IDW = $clog2(N_REQ);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_SCAN  = 3'd2;
    localparam logic [2:0] S_MARK  = 3'd3;
    localparam logic [2:0] S_READY = 3'd4;

    logic [2:0]     state_q, state_d;
    logic [255:0]   bm_q, bm_d;
    logic [4:0]     i_q, i_d;
    logic [8:0]     j_q, j_d;
    logic [IDW-1:0] rr_q, rr_d;
    logic           done_q, done_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic           rsp_prime_q, rsp_prime_d;

    logic [9:0]     i_sq;
    logic [8:0]     j_next;
    logic [N_REQ-1:0] gnt;
    logic           gnt_any;
    logic [IDW-1:0] gnt_id;
    logic [7:0]     sel_num;
    int unsigned    scan_idx;

    assign i_sq   = 10'(i_q) * 10'(i_q);
    assign j_next = j_q + {4'd0, i_q};

    // Round-robin search starting at rr_q, wrapping; only active in READY.
    always_comb begin
        gnt      = '0;
        gnt_any  = 1'b0;
        gnt_id   = '0;
        sel_num  = '0;
        scan_idx = 0;
        if (state_q == S_READY) begin
            for (int unsigned n = 0; n < N_REQ; n++) begin
                scan_idx = int'(rr_q) + n;
                if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
                if (!gnt_any && req_valid[scan_idx]) begin
                    gnt_any       = 1'b1;
                    gnt[scan_idx] = 1'b1;
                    gnt_id        = IDW'(scan_idx);
                    sel_num       = req_num[8*scan_idx +: 8];
                end
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (gnt_any) begin
            if (int'(gnt_id) == N_REQ - 1) rr_d = '0;
            else                           rr_d = gnt_id + 1'b1;
        end
        rsp_valid_d = gnt_any;
        rsp_id_d    = gnt_id;
        rsp_prime_d = gnt_any & bm_q[sel_num];
    end

    always_comb begin
        state_d = state_q;
        bm_d    = bm_q;
        i_d     = i_q;
        j_d     = j_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                bm_d    = {{254{1'b1}}, 2'b00};
                i_d     = 5'd2;
                state_d = S_SCAN;
            end
            S_SCAN: begin
                if (i_sq > 10'd255) begin
                    state_d = S_READY;
                    done_d  = 1'b1;
                end else if (bm_q[i_q]) begin
                    j_d     = i_sq[8:0];
                    state_d = S_MARK;
                end else begin
                    i_d = i_q + 5'd1;
                end
            end
            S_MARK: begin
                // Clear unconditionally; the 9-bit sum exposes the step past 255.
                bm_d[j_q[7:0]] = 1'b0;
                if (j_next > 9'd255) begin
                    i_d     = i_q + 5'd1;
                    state_d = S_SCAN;
                end else begin
                    j_d = j_next;
                end
            end
            S_READY: begin
                if (start) state_d = S_CLEAR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bm_q        <= '0;
            i_q         <= '0;
            j_q         <= '0;
            rr_q        <= '0;
            done_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_prime_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bm_q        <= bm_d;
            i_q         <= i_d;
            j_q         <= j_d;
            rr_q        <= rr_d;
            done_q      <= done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_prime_q <= rsp_prime_d;
        end
    end

    assign busy      = (state_q == S_CLEAR) || (state_q == S_SCAN) || (state_q == S_MARK);
    assign done      = done_q;
    assign req_ready = gnt;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_prime = rsp_prime_q;

`ifdef PRIME_SIEVE_STATS_EN
    logic [15:0] hits_q, hits_d;

    always_comb begin
        hits_d = hits_q;
        if (state_d == S_CLEAR) begin
            hits_d = '0;
        end else if (rsp_valid_q && rsp_prime_q && (hits_q != '1)) begin
            hits_d = hits_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) hits_q <= '0;
        else     hits_q <= hits_d;
    end

    assign prime_hits = hits_q;
`endif

endmodule

// File: tb/tb_prime_sieve_ctrl.sv
// Scoreboard bench for prime_sieve_ctrl: grants and responses checked against a trial-division model.
// Also checks prime_hits when PRIME_SIEVE_STATS_EN is defined.
module tb_prime_sieve_ctrl;

    localparam int NR  = 2;
    localparam int IDW = $clog2(NR);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            busy, done, rsp_valid, rsp_prime;
    logic [NR-1:0]   req_valid = '0;
    logic [8*NR-1:0] req_num = '0;
    logic [NR-1:0]   req_ready;
    logic [IDW-1:0]  rsp_id;
`ifdef PRIME_SIEVE_STATS_EN
    logic [15:0]     prime_hits;
`endif

    prime_sieve_ctrl #(.N_REQ(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .req_valid (req_valid),
        .req_num   (req_num),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_prime (rsp_prime)
`ifdef PRIME_SIEVE_STATS_EN
        ,
        .prime_hits(prime_hits)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        bit prime;
    } exp_t;

    int          vectors = 0;
    int          miscompares = 0;
    bit          model_ready = 0;
    bit          model_busy = 0;
    bit          model_ready_prev = 0;
    int          model_rr = 0;
    int unsigned model_hits = 0;
    int          prime_rsp_cnt = 0;
    bit          expect_rsp = 0;
    bit          gaps = 0;
    logic [NR-1:0] granted = '0;
    logic [7:0]  pend [NR][$];
    exp_t        sb [$];

    int          exp_k;
    logic [NR-1:0] exp_gnt;
    exp_t        e;

    function automatic bit is_prime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++)
            if (n % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: response checks first, then this cycle's grant feeds the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            expect_rsp       = 0;
            granted          = '0;
            model_ready_prev = 0;
        end else begin
            check("busy", busy, model_busy);
            check("done", done, model_ready && !model_ready_prev);
            model_ready_prev = model_ready;
            check("rsp_valid", rsp_valid, expect_rsp);
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rsp_unexpected: got response id %0d, expected none at %0t", rsp_id, $time);
                end else begin
                    e = sb.pop_front();
                    check("rsp_id", rsp_id, e.id);
                    check("rsp_prime", rsp_prime, e.prime);
                    if (rsp_prime) prime_rsp_cnt++;
                end
            end
            exp_k = -1;
            for (int n = 0; n < NR; n++) begin
                if (exp_k < 0 && req_valid[(model_rr + n) % NR]) exp_k = (model_rr + n) % NR;
            end
            exp_gnt = '0;
            if (model_ready && exp_k >= 0) exp_gnt[exp_k] = 1'b1;
            check("req_ready", req_ready, exp_gnt);
            granted    = req_valid & req_ready;
            expect_rsp = model_ready && (exp_k >= 0);
            if (expect_rsp) begin
                sb.push_back('{id: exp_k, prime: is_prime(int'(req_num[8*exp_k +: 8]))});
                if (is_prime(int'(req_num[8*exp_k +: 8])) && model_hits != 16'hFFFF) model_hits++;
                model_rr = (exp_k + 1) % NR;
            end
        end
    end

    // Requester driver: holds each request until the handshake completes.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < NR; k++) begin
                if (req_valid[k] && granted[k]) req_valid[k] = 1'b0;
                if (!req_valid[k] && pend[k].size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
                    req_num[8*k +: 8] = pend[k].pop_front();
                    req_valid[k]      = 1'b1;
                end
            end
        end
    end

    task automatic start_build();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        model_ready = 0;
        model_busy  = 1;
        model_hits  = 0;
    endtask

    task automatic finish_build(input int already);
        repeat (322 - already) @(posedge clk);
        #1;
        model_busy  = 0;
        model_ready = 1;
`ifdef PRIME_SIEVE_STATS_EN
        check("hits_after_build", prime_hits, 0);
`endif
    endtask

    task automatic wait_drain();
        bit idle;
        idle = 0;
        for (int c = 0; c < 5000 && !idle; c++) begin
            @(posedge clk);
            idle = (req_valid == '0) && (sb.size() == 0) && !expect_rsp;
            for (int k = 0; k < NR; k++) if (pend[k].size() != 0) idle = 0;
        end
        if (!idle) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got outstanding requests, expected none at %0t", $time);
        end
        repeat (2) @(posedge clk);
        #1;
`ifdef PRIME_SIEVE_STATS_EN
        check("prime_hits", prime_hits, model_hits);
`endif
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_id"}, rsp_id, 0);
        check({tag, "_rsp_prime"}, rsp_prime, 0);
`ifdef PRIME_SIEVE_STATS_EN
        check({tag, "_hits"}, prime_hits, 0);
`endif
    endtask

    initial begin
        logic [7:0] list [7];
        list = '{8'd0, 8'd1, 8'd2, 8'd97, 8'd221, 8'd251, 8'd255};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;

        // First build with an ignored start pulse part-way through.
        start_build();
        repeat (100) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        finish_build(101);

        for (int n = 0; n < 7; n++) pend[0].push_back(list[n]);
        wait_drain();

        for (int n = 0; n < 8; n++) begin
            pend[0].push_back(8'd7);
            pend[1].push_back(8'd9);
        end
        wait_drain();

        // Full sweep: each entry is checked, and the total must be the 54 primes below 256.
        prime_rsp_cnt = 0;
        gaps = 1;
        for (int n = 0; n < 256; n++) pend[n % NR].push_back(8'(n));
        wait_drain();
        check("prime_count", prime_rsp_cnt, 54);

        for (int n = 0; n < 200; n++) pend[$urandom_range(0, NR - 1)].push_back(8'($urandom_range(0, 255)));
        wait_drain();
        gaps = 0;

        // Queries raised during a rebuild must wait for the first READY cycle.
        start_build();
        pend[1].push_back(8'd13);
        pend[0].push_back(8'd4);
        finish_build(0);
        wait_drain();

        // Reset during the marking pass for prime 3, then a clean rebuild.
        start_build();
        repeat (139) @(posedge clk);
        #1 rst = 1'b1;
        model_busy  = 0;
        model_ready = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        model_rr   = 0;
        model_hits = 0;
        check_outputs_zero("mid_mark_reset");
        start_build();
        finish_build(0);
        pend[0].push_back(8'd9);
        pend[1].push_back(8'd3);
        pend[0].push_back(8'd243);
        pend[1].push_back(8'd241);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/prime_sieve_ctrl.md
# prime_sieve_ctrl

Multi-cycle sequencer and query arbiter for the 256-entry prime sieve bitmap. On `start` it builds the Sieve of Eratosthenes over 0..255, clearing one composite bit per clock. It then serves primality lookups from `N_REQ` independent requesters through a round-robin arbiter, one lookup per cycle. It replaces the single-cycle, single-user sieve lookup path in the prime-detection design.

## Interface
- `N_REQ`, default 2: number of query requesters, 2..8.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: build request, sampled only in IDLE or READY.
- `busy`  out  1: high while the build is in progress (CLEAR/SCAN/MARK).
- `done`  out  1: one-cycle pulse on entry to READY.
- `req_valid`  in  N_REQ: per-requester query valid.
- `req_num`  in  8*N_REQ: per-requester number to test; requester k uses bits [8k+7:8k].
- `req_ready`  out  N_REQ: one-hot grant, combinational.
- `rsp_valid`  out  1: response valid, registered.
- `rsp_id`  out  $clog2(N_REQ): index of the requester being answered.
- `rsp_prime`  out  1: 1 if the queried number is prime.

## Operation
- Storage: 256-bit flop vector `bm`. After reset, all bits are 0.
- FSM states: IDLE, CLEAR, SCAN, MARK, READY. Reset state is IDLE.
- IDLE: if `start`=1, go to CLEAR.
- CLEAR (1 cycle): set `bm` to all ones except bits 0 and 1, which are 0. Set `i`=2. Go to SCAN.
- SCAN (1 cycle per evaluation):
  - If i*i > 255, go to READY.
  - Else if `bm[i]`=1, set `j`=i*i and go to MARK.
  - Else increment `i` and stay in SCAN.
- MARK (1 cycle per composite write): clear `bm[j]`, then j += i.
  - `j` is 9 bits wide, so overflow past 255 is detectable.
  - When j+i > 255, the current cycle is the last mark: increment `i` and return to SCAN.
  - A bit already cleared is written again; no skip logic.
- `i` is 5 bits wide and never exceeds 16.
- READY: the bitmap is valid and queries are served. `start`=1 goes to CLEAR (rebuild). A query granted in that same cycle is still answered from the old bitmap.
- Arbitration applies only in READY. In every other state `req_ready` is 0.
  - Round-robin pointer `rr`. The grant goes to the first requester with `req_valid` set, searching from `rr` upward with wrap.
  - After a grant to requester k, `rr` becomes k+1 mod N_REQ. `rr` is unchanged when nothing is granted.
- Handshake: a transfer occurs when `req_valid[k]` and `req_ready[k]` are both 1.
  - A requester holds `req_valid` and `req_num` stable until granted.
  - `req_ready` never depends on `req_valid` of the same requester being deasserted.
- `start` while `busy`=1: ignored.
- `rst` during any state (including mid-MARK):
  - Next cycle: state=IDLE, `bm`=0, `i`=0, `j`=0, `rr`=0.
  - All outputs are 0. Any pending response is discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_prime`=0.
- Build latency: `start` sampled at edge E; CLEAR occupies cycle E+1; `busy`=1 for exactly 322 cycles.
  - Breakdown: 1 CLEAR + 15 SCAN + 306 MARK.
  - MARK count per prime: 2→126, 3→83, 5→47, 7→30, 11→13, 13→7.
- `done`=1 in the first READY cycle, the cycle after `busy` falls. It is asserted for that cycle only.
- Query latency: a grant at edge G produces `rsp_valid`=1, `rsp_id`=k, `rsp_prime`=`bm[req_num_k]` during cycle G+1.
  - `rsp_valid` is 0 in any cycle with no preceding grant.
  - There is no backpressure on responses.
- Throughput: one query per cycle. With all requesters valid, each is granted once per N_REQ cycles.

## Configuration
- `PRIME_SIEVE_STATS_EN` defined:
  - Adds output `prime_hits` (16 bits). It counts responses with `rsp_prime`=1 and saturates at 0xFFFF.
  - Cleared by `rst` and on entry to CLEAR.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset, pulse `start` → `busy` high exactly 322 cycles, then `done` one-cycle pulse; `bm` holds exactly 54 ones.
- READY, requester 0 queries 0, 1, 2, 97, 221 (=13·17), 251, 255 → `rsp_prime` = 0, 1... specifically 0, 0, 1, 1, 0, 1, 0, each with `rsp_id`=0, one cycle after its grant.
- N_REQ=2, both valid continuously with numbers 7 and 9 → grants alternate 0, 1, 0, 1; responses alternate (id 0, prime 1) and (id 1, prime 0).
- Query asserted during build → `req_ready`=0 until the first READY cycle, then granted immediately. `start` pulsed mid-build → no change to the 322-cycle count.
- `rst` asserted in MARK for prime 3 → next cycle IDLE, all outputs 0; a subsequent `start` rebuilds correctly (query 9 → 0).
- With `PRIME_SIEVE_STATS_EN`: 10 queries of 2, 4, 5, ... (6 primes) → `prime_hits`=6; the count clears on rebuild.
